// File: rtl/mmio_pkg.sv
// Shared types and constants for the JTAG UART MMIO sequencer.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] UART_DATA_OFS  = 32'd0;
  localparam logic [31:0] UART_CTRL_OFS  = 32'd4;
  localparam logic [31:0] ERR_RDATA_DFLT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Wait-state counter: synchronous clear, count enable, terminal count at LIMIT-1.
module mmio_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/jtag_uart_mmio_ctrl.sv
// Avalon-MM master sequencer for the JTAG UART window; stalls the pipeline per access.
// Optional wait-state abort is enabled by defining MMIO_TIMEOUT_EN.
module jtag_uart_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h100,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  output logic        mem_hit,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        av_chipselect,
  output logic        av_address,
  output logic        av_read_n,
  output logic        av_write_n,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic        timeout_err
);

  state_e      state_q, state_d;
  logic        req;
  logic        abort;

  logic        cs_q, cs_d;
  logic        addr_q, addr_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  assign mem_hit = (mem_addr == BASE_ADDR + UART_DATA_OFS) |
                   (mem_addr == BASE_ADDR + UART_CTRL_OFS);
  assign req     = mem_hit & (mem_read | mem_write);

`ifdef MMIO_TIMEOUT_EN
  logic tc;
  logic terr_q;

  mmio_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i ((state_q == IDLE) & req),
    .en_i  ((state_q == BUS) & av_waitrequest),
    .tc_o  (tc)
  );

  assign abort = (state_q == BUS) & av_waitrequest & tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      terr_q <= 1'b0;
    end else if (abort) begin
      terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = BUS;
      BUS:     if (!av_waitrequest || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are computed here but only ever leave the block through registers.
  always_comb begin
    stall   = 1'b0;
    cs_d    = cs_q;
    addr_d  = addr_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          cs_d    = 1'b1;
          addr_d  = mem_addr[2];
          wdata_d = mem_wdata;
          wr_n_d  = ~mem_write;
          rd_n_d  = ~(mem_read & ~mem_write);
        end
      end
      BUS: begin
        stall = 1'b1;
        if (!av_waitrequest || abort) begin
          cs_d   = 1'b0;
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          if (!rd_n_q) begin
            rdata_d = abort ? ERR_RDATA : av_readdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= 1'b0;
      addr_q  <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign av_chipselect = cs_q;
  assign av_address    = addr_q;
  assign av_read_n     = rd_n_q;
  assign av_write_n    = wr_n_q;
  assign av_writedata  = wdata_q;
  assign mem_rdata     = rdata_q;

endmodule

// File: tb/tb_jtag_uart_mmio_ctrl.sv
// Self-checking bench for jtag_uart_mmio_ctrl: vector table, Avalon scoreboard, corner sequences.
module tb_jtag_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_hit;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        av_chipselect;
  logic        av_address;
  logic        av_read_n;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic        timeout_err;

  always #5 clk = ~clk;

  jtag_uart_mmio_ctrl #(
    .BASE_ADDR      (32'h100),
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_hit        (mem_hit),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .timeout_err    (timeout_err)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  typedef struct packed {
    logic        adr;
    logic        rd_n;
    logic        wr_n;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb_q[$];
  txn_t        cur = '0;
  logic        prev_cs = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_issue = 0;
  int unsigned last_issue = 0;
  int unsigned prev_issue = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Avalon monitor: pops the expected transaction on each new issue, checks it is held while selected.
  always @(negedge clk) begin
    if (av_chipselect && !prev_cs) begin
      n_issue++;
      prev_issue = last_issue;
      last_issue = cyc;
      if (sb_q.size() == 0) check("unexpected_issue", 32'(n_issue), 32'd0);
      else cur = sb_q.pop_front();
    end
    if (av_chipselect) begin
      check("av_address", 32'(av_address), 32'(cur.adr));
      check("av_read_n", 32'(av_read_n), 32'(cur.rd_n));
      check("av_write_n", 32'(av_write_n), 32'(cur.wr_n));
      check("av_writedata", av_writedata, cur.wdata);
    end
    prev_cs = av_chipselect;
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned n_wait;
    logic        hit;
    int unsigned stalls;
    int unsigned strobes;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic rd,
                              input logic wr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input int unsigned n_wait, input logic hit, input int unsigned stalls,
                              input int unsigned strobes, input logic [31:0] exp_rdata);
    vec_t v;
    v.name = name; v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wdata; v.rdata = rdata;
    v.n_wait = n_wait; v.hit = hit; v.stalls = stalls; v.strobes = strobes;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // One MEM-stage instruction: held while stall is high, slave inserts n_wait wait states.
  task automatic run_access(input vec_t v);
    int unsigned stall_cnt = 0;
    int unsigned strb_cnt  = 0;
    int unsigned busc      = 0;
    bit          done      = 1'b0;
    txn_t        t;
    @(negedge clk);
    mem_addr       = v.addr;
    mem_read       = v.rd;
    mem_write      = v.wr;
    mem_wdata      = v.wdata;
    av_readdata    = v.rdata;
    av_waitrequest = 1'b1;
    if (v.hit && (v.rd || v.wr)) begin
      t.adr   = v.addr[2];
      t.rd_n  = ~(v.rd & ~v.wr);
      t.wr_n  = ~v.wr;
      t.wdata = v.wdata;
      sb_q.push_back(t);
    end
    #1;
    check({v.name, ".hit"}, 32'(mem_hit), 32'(v.hit));
    for (int c = 0; c < 64; c++) begin
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      if (!av_read_n || !av_write_n) begin
        strb_cnt++;
        av_waitrequest = (busc < v.n_wait);
        busc++;
      end
      @(negedge clk);
    end
    av_waitrequest = 1'b1;
    if (!done) check({v.name, ".retire_bound"}, 32'd0, 32'd1);
    check({v.name, ".stall_cycles"}, stall_cnt, v.stalls);
    check({v.name, ".strobe_cycles"}, strb_cnt, v.strobes);
    check({v.name, ".mem_rdata"}, mem_rdata, v.exp_rdata);
  endtask

  vec_t vecs[9];
  int unsigned base_issue;

  initial begin
    vecs[0] = mk("rd_ctrl_w0",   32'h104, 1, 0, 32'h0,        32'h00FF0001, 0, 1, 2, 1, 32'h00FF0001);
    vecs[1] = mk("wr_data_w3",   32'h100, 0, 1, 32'h41,       32'h0,        3, 1, 5, 4, 32'h00FF0001);
    vecs[2] = mk("rd_nohit_80",  32'h080, 1, 0, 32'h0,        32'h99999999, 0, 0, 0, 0, 32'h00FF0001);
    vecs[3] = mk("rd_data_w1",   32'h100, 1, 0, 32'h0,        32'hDEADBEEF, 1, 1, 3, 2, 32'hDEADBEEF);
    vecs[4] = mk("rdwr_as_wr",   32'h104, 1, 1, 32'h12345678, 32'hCAFEF00D, 0, 1, 2, 1, 32'hDEADBEEF);
    vecs[5] = mk("wr_nohit_108", 32'h108, 0, 1, 32'h55,       32'h0,        0, 0, 0, 0, 32'hDEADBEEF);
    vecs[6] = mk("hit_no_rw",    32'h100, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 32'hDEADBEEF);
    vecs[7] = mk("rd_nohit_fc",  32'h0FC, 1, 0, 32'h0,        32'h1,        0, 0, 0, 0, 32'hDEADBEEF);
    vecs[8] = mk("rd_nohit_101", 32'h101, 1, 0, 32'h0,        32'h2,        0, 0, 0, 0, 32'hDEADBEEF);

    rst = 1'b1; mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
    av_readdata = '0; av_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.av_chipselect", 32'(av_chipselect), 32'd0);
    check("rst.av_read_n", 32'(av_read_n), 32'd1);
    check("rst.av_write_n", 32'(av_write_n), 32'd1);
    check("rst.av_address", 32'(av_address), 32'd0);
    check("rst.av_writedata", av_writedata, 32'd0);
    check("rst.mem_rdata", mem_rdata, 32'd0);
    check("rst.timeout_err", 32'(timeout_err), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_access(vecs[i]);

    // Back-to-back reads: second issues in the IDLE cycle after DONE.
    base_issue = n_issue;
    run_access(mk("b2b_0", 32'h100, 1, 0, 32'h0, 32'h11112222, 0, 1, 2, 1, 32'h11112222));
    run_access(mk("b2b_1", 32'h100, 1, 0, 32'h0, 32'h33334444, 0, 1, 2, 1, 32'h33334444));
    check("b2b.issue_count", n_issue - base_issue, 32'd2);
    check("b2b.issue_interval", last_issue - prev_issue, 32'd3);

    // Reset during the second wait-state cycle of a read; slave completes on that same edge.
    @(negedge clk);
    mem_addr = 32'h100; mem_read = 1'b1; mem_write = 1'b0; mem_wdata = 32'h0;
    av_readdata = 32'h5555AAAA; av_waitrequest = 1'b1;
    sb_q.push_back(txn_t'{adr: 1'b0, rd_n: 1'b0, wr_n: 1'b1, wdata: 32'h0});
    @(negedge clk);
    check("rstbus.in_bus", 32'(av_chipselect), 32'd1);
    @(negedge clk);
    rst = 1'b1; av_waitrequest = 1'b0;
    @(negedge clk);
    check("rstbus.av_chipselect", 32'(av_chipselect), 32'd0);
    check("rstbus.av_read_n", 32'(av_read_n), 32'd1);
    check("rstbus.mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0; mem_read = 1'b0; av_waitrequest = 1'b1;
    #1;
    check("rstbus.idle_stall", 32'(stall), 32'd0);

    run_access(mk("recover_w2", 32'h104, 1, 0, 32'h0, 32'h0BADF00D, 2, 1, 4, 3, 32'h0BADF00D));

`ifdef MMIO_TIMEOUT_EN
    run_access(mk("timeout_rd", 32'h104, 1, 0, 32'h0, 32'h77, 100, 1, 5, 4, 32'hFFFF_FFFF));
    check("timeout.err_set", 32'(timeout_err), 32'd1);
    run_access(mk("after_timeout", 32'h100, 1, 0, 32'h0, 32'h2468, 0, 1, 2, 1, 32'h2468));
    check("timeout.err_sticky", 32'(timeout_err), 32'd1);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("timeout.err_cleared", 32'(timeout_err), 32'd0);
`else
    run_access(mk("long_wait_rd", 32'h104, 1, 0, 32'h0, 32'h77, 10, 1, 12, 11, 32'h77));
    check("no_timeout.err", 32'(timeout_err), 32'd0);
`endif

    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    check("sb.empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
